// File: rtl/iq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_pkg: shared sizes, FU encodings and entry type for the CIQ select |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package iq_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IDX_W    = 5;

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_MUL = 2'b01;
  localparam logic [1:0] FU_LS  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] fu;
    logic       rdy1;
    logic       rdy2;
  } iq_entry_t;

  // The reserved encoding 2'b11 is steered to the ALU ports.
  function automatic logic is_alu(input logic [1:0] fu);
    return (fu == FU_ALU) || (fu == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_age_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_age_pick: oldest requester from an age matrix (one-hot + index)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iq_age_pick
  import iq_pkg::*;
(
  input  logic [IQ_DEPTH-1:0]               req,
  input  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] older,
  output logic [IQ_DEPTH-1:0]               pick_oh,
  output logic [IDX_W-1:0]                  pick_idx,
  output logic                              found
);

  // Entry i wins when no other requester is older than it.
  genvar gi;
  for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_win
    logic [IQ_DEPTH-1:0] not_self;
    assign not_self    = ~(IQ_DEPTH'(1) << gi);
    assign pick_oh[gi] = req[gi] & ~|(req & ~older[gi] & not_self);
  end

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (pick_oh[i]) pick_idx = IDX_W'(i);
    end
  end

  assign found = |pick_oh;

endmodule
`default_nettype wire

// File: rtl/iq_issue_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_issue_select: 16-entry CIQ age-ordered issue select, 4 ports      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iq_issue_select
  import iq_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                alloc_valid,
  input  logic [1:0]          alloc_fu,
  input  logic                alloc_rdy1,
  input  logic                alloc_rdy2,
  output logic                alloc_ready,
  output logic [IDX_W-1:0]    alloc_idx,
  input  logic [IQ_DEPTH-1:0] wake_prs1,
  input  logic [IQ_DEPTH-1:0] wake_prs2,
  input  logic                ls_ready,
  output logic                grant_alu0,
  output logic                grant_alu1,
  output logic                grant_mul,
  output logic                grant_ls,
  output logic [IDX_W-1:0]    addr_alu0,
  output logic [IDX_W-1:0]    addr_alu1,
  output logic [IDX_W-1:0]    addr_mul,
  output logic [IDX_W-1:0]    addr_ls,
  output logic [IDX_W-1:0]    free_cnt
);

  localparam int               MB_W       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MB_W-1:0]  MUL_RELOAD = MB_W'(MUL_LAT - 1);
  localparam logic [IDX_W-1:0] FREE_ALL   = IDX_W'(IQ_DEPTH);

  iq_entry_t [IQ_DEPTH-1:0]               ent_q, ent_d;
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]      older_q, older_d;
  logic [MB_W-1:0]                        mul_busy_q, mul_busy_d;
  logic                                   grant_alu0_q, grant_alu1_q, grant_mul_q, grant_ls_q;
  logic                                   grant_alu0_d, grant_alu1_d, grant_mul_d, grant_ls_d;
  logic [IDX_W-1:0]                       addr_alu0_q, addr_alu1_q, addr_mul_q, addr_ls_q;
  logic [IDX_W-1:0]                       addr_alu0_d, addr_alu1_d, addr_mul_d, addr_ls_d;
  logic [IDX_W-1:0]                       free_cnt_q, free_cnt_d;

  logic [IQ_DEPTH-1:0] valid_vec, req_alu, req_alu1, req_mul, req_ls;
  logic [IQ_DEPTH-1:0] alu0_oh, alu1_oh, mul_oh, ls_oh, grant_vec, alloc_oh;
  logic [IDX_W-1:0]    alu0_idx, alu1_idx, mul_idx, ls_idx;
  logic                alu0_found, alu1_found, mul_found, ls_found;
  logic                alloc_fire;
  logic [2:0]          n_grants;

  always_comb begin
    valid_vec = '0;
    req_alu   = '0;
    req_mul   = '0;
    req_ls    = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      logic elig;
      elig         = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
      valid_vec[i] = ent_q[i].valid;
      req_alu[i]   = elig & is_alu(ent_q[i].fu);
      req_mul[i]   = elig & (ent_q[i].fu == FU_MUL) & (mul_busy_q == '0);
      req_ls[i]    = elig & (ent_q[i].fu == FU_LS) & ls_ready;
    end
  end

  assign req_alu1 = req_alu & ~alu0_oh;

  iq_age_pick u_pick_alu0 (
    .req(req_alu),  .older(older_q), .pick_oh(alu0_oh), .pick_idx(alu0_idx), .found(alu0_found)
  );
  iq_age_pick u_pick_alu1 (
    .req(req_alu1), .older(older_q), .pick_oh(alu1_oh), .pick_idx(alu1_idx), .found(alu1_found)
  );
  iq_age_pick u_pick_mul (
    .req(req_mul),  .older(older_q), .pick_oh(mul_oh),  .pick_idx(mul_idx),  .found(mul_found)
  );
  iq_age_pick u_pick_ls (
    .req(req_ls),   .older(older_q), .pick_oh(ls_oh),   .pick_idx(ls_idx),   .found(ls_found)
  );

  assign grant_vec = alu0_oh | alu1_oh | mul_oh | ls_oh;

  // Lowest free slot, taken from registered valid so freed-this-cycle entries stay busy.
  always_comb begin
    alloc_idx = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign alloc_ready = (free_cnt_q != '0);
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign alloc_oh    = alloc_fire ? (IQ_DEPTH'(1) << alloc_idx) : '0;

  always_comb begin
    ent_d   = ent_q;
    older_d = older_q;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (flush) begin
        ent_d[i] = '0;
      end else if (alloc_oh[i]) begin
        ent_d[i] = '{valid: 1'b1, fu: alloc_fu, rdy1: alloc_rdy1, rdy2: alloc_rdy2};
        // Newcomer is younger than every surviving entry and older than none.
        older_d[i] = '0;
        for (int j = 0; j < IQ_DEPTH; j++) begin
          older_d[j][i] = valid_vec[j] & ~grant_vec[j];
        end
      end else if (valid_vec[i]) begin
        ent_d[i].rdy1 = ent_q[i].rdy1 | wake_prs1[i];
        ent_d[i].rdy2 = ent_q[i].rdy2 | wake_prs2[i];
        if (grant_vec[i]) ent_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    grant_alu0_d = ~flush & alu0_found;
    grant_alu1_d = ~flush & alu1_found;
    grant_mul_d  = ~flush & mul_found;
    grant_ls_d   = ~flush & ls_found;
    addr_alu0_d  = grant_alu0_d ? alu0_idx : addr_alu0_q;
    addr_alu1_d  = grant_alu1_d ? alu1_idx : addr_alu1_q;
    addr_mul_d   = grant_mul_d  ? mul_idx  : addr_mul_q;
    addr_ls_d    = grant_ls_d   ? ls_idx   : addr_ls_q;

    n_grants = 3'(grant_alu0_d) + 3'(grant_alu1_d) + 3'(grant_mul_d) + 3'(grant_ls_d);

    if (flush) begin
      free_cnt_d = FREE_ALL;
    end else begin
      free_cnt_d = free_cnt_q - IDX_W'(alloc_fire) + IDX_W'(n_grants);
    end

    if (flush) begin
      mul_busy_d = '0;
    end else if (mul_found) begin
      mul_busy_d = MUL_RELOAD;
    end else if (mul_busy_q != '0) begin
      mul_busy_d = mul_busy_q - 1'b1;
    end else begin
      mul_busy_d = mul_busy_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q        <= '0;
      older_q      <= '0;
      mul_busy_q   <= '0;
      grant_alu0_q <= 1'b0;
      grant_alu1_q <= 1'b0;
      grant_mul_q  <= 1'b0;
      grant_ls_q   <= 1'b0;
      addr_alu0_q  <= '0;
      addr_alu1_q  <= '0;
      addr_mul_q   <= '0;
      addr_ls_q    <= '0;
      free_cnt_q   <= FREE_ALL;
    end else begin
      ent_q        <= ent_d;
      older_q      <= older_d;
      mul_busy_q   <= mul_busy_d;
      grant_alu0_q <= grant_alu0_d;
      grant_alu1_q <= grant_alu1_d;
      grant_mul_q  <= grant_mul_d;
      grant_ls_q   <= grant_ls_d;
      addr_alu0_q  <= addr_alu0_d;
      addr_alu1_q  <= addr_alu1_d;
      addr_mul_q   <= addr_mul_d;
      addr_ls_q    <= addr_ls_d;
      free_cnt_q   <= free_cnt_d;
    end
  end

  assign grant_alu0 = grant_alu0_q;
  assign grant_alu1 = grant_alu1_q;
  assign grant_mul  = grant_mul_q;
  assign grant_ls   = grant_ls_q;
  assign addr_alu0  = addr_alu0_q;
  assign addr_alu1  = addr_alu1_q;
  assign addr_mul   = addr_mul_q;
  assign addr_ls    = addr_ls_q;
  assign free_cnt   = free_cnt_q;

endmodule
`default_nettype wire
